// File: rtl/shuf_encode.sv
// shuf_encode: two-stage pipelined inverse of the rotated one-hot lane shuffle decoder.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_sel holds eight one-hot select bytes
//   out_valid/out_ready  output handshake; out_fld holds eight 3-bit fields (one per byte)
//   out_err              per-lane flag: lane is not exactly one-hot
//   err_clr              synchronous clear of err_cnt/err_sticky (wins over an increment)
//   err_cnt, err_sticky  saturating count / sticky flag of transferred erroneous words
module shuf_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_fld,
  output logic [7:0]       out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);
  logic        s1_valid;
  logic [63:0] s1_sel;
  logic [63:0] dec_fld;
  logic [7:0]  dec_err;
  logic        s2_adv;
  logic        s1_adv;
  logic        out_xfer;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = out_valid && out_ready;
  // Scanning from the top bit down leaves the lowest set bit's field in place.
  always_comb begin
    dec_fld = '0;
    dec_err = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 7; j >= 0; j--)
        if (s1_sel[8*i+j]) dec_fld[8*i +: 3] = 3'(i - j);
      dec_err[i] = (s1_sel[8*i +: 8] == 8'd0) ||
                   ((s1_sel[8*i +: 8] & (s1_sel[8*i +: 8] - 8'd1)) != 8'd0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_sel <= in_sel;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_fld   <= '0;
      out_err   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_fld <= dec_fld;
        out_err <= dec_err;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (out_xfer && |out_err) begin
      err_cnt    <= &err_cnt ? err_cnt : err_cnt + 1'b1;
      err_sticky <= 1'b1;
    end
  end
endmodule
